cordic_seq_core: RTL and testbench

Iterative, one-micro-rotation-per-cycle CORDIC engine. It is the responder side of the calculator command protocol: enable pulse with operation and x/y/z operands in, result plus level done out. It serves the circular ops (SIN, COS, ATAN, MOD) and linear ops (MULT, DIV) in signed Q16.16, and slots in as the compute core behind the calculator top level.

---
 rtl/cordic_seq_core.sv | 249 ++++++++++++++++++++++++
 tb/tb_cordic_seq_core.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cordic_seq_core.sv
// cordic_seq_core: iterative CORDIC engine, one micro-rotation per clock.
// Serves SIN/COS (circular rotation), ATAN/MOD (circular vectoring) and
// MULT/DIV (linear rotation/vectoring) on signed Q(WIDTH-FRAC).FRAC data.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   enable          request strobe, sampled only while idle
//   operation[3:0]  0 SIN, 1 COS, 2 ATAN, 3 MOD, 4 MULT, 5 DIV
//   x_in/y_in/z_in  operands
//   result          registered result, held until the next accept
//   done            level, high from completion until the next accept
//   busy            high while preparing or iterating
//   op_error        valid with done: unsupported op or DIV by zero
//   dbg_state       current FSM state, for checkers
//
// Handshake: a request is accepted on any rising edge where the core is
// IDLE and enable=1. That edge clears done/op_error. Enables seen in any
// other state are dropped, not queued. done stays high until the next
// accepted request.
module cordic_seq_core #(
    parameter int WIDTH      = 32,
    parameter int FRAC       = 16,
    parameter int ITERATIONS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [3:0]              operation,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic signed [WIDTH-1:0] result,
    output logic                    done,
    output logic                    busy,
    output logic                    op_error,
    output logic [1:0]              dbg_state
);
    localparam int IW = WIDTH + 2;   // internal adder width with headroom
    localparam int W2 = 2 * IW;      // width for the MOD gain multiply
    localparam int CW = 5;           // iteration counter, covers 0..24

    localparam logic [3:0] OP_SIN  = 4'd0;
    localparam logic [3:0] OP_COS  = 4'd1;
    localparam logic [3:0] OP_ATAN = 4'd2;
    localparam logic [3:0] OP_MOD  = 4'd3;
    localparam logic [3:0] OP_MULT = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;

    localparam logic signed [IW-1:0] K_C     = IW'(39797);
    localparam logic signed [IW-1:0] HALF_PI = IW'(102944);
    localparam logic signed [IW-1:0] PI_C    = IW'(205887);
    localparam logic signed [IW-1:0] ONE     = IW'(1) <<< FRAC;
    localparam logic signed [W2-1:0] MAXV    = W2'({1'b0, {(WIDTH-1){1'b1}}});
    localparam logic signed [W2-1:0] MINV    = -MAXV - W2'(1);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIN} state_t;
    state_t state, next_state;

    logic [CW-1:0]           iter;
    logic [3:0]              op_q;
    logic signed [WIDTH-1:0] xq, yq, zq;
    logic                    bad_q;
    logic signed [IW-1:0]    xr, yr, zr, off_r;
    logic                    flip_r;

    logic signed [IW-1:0]    px, py, pz, poff;
    logic                    pflip;
    logic signed [IW-1:0]    x_n, y_n, z_n, xs, ys, at, lin;
    logic                    d_pos;
    logic signed [W2-1:0]    fin_w, prod;

    function automatic logic signed [IW-1:0] sext(input logic signed [WIDTH-1:0] v);
        return IW'(v);
    endfunction

    function automatic logic signed [IW-1:0] atan_rom(input logic [CW-1:0] i);
        case (i)
            5'd0:  return IW'(51472);
            5'd1:  return IW'(30386);
            5'd2:  return IW'(16055);
            5'd3:  return IW'(8150);
            5'd4:  return IW'(4091);
            5'd5:  return IW'(2047);
            5'd6:  return IW'(1024);
            5'd7:  return IW'(512);
            5'd8:  return IW'(256);
            5'd9:  return IW'(128);
            5'd10: return IW'(64);
            5'd11: return IW'(32);
            5'd12: return IW'(16);
            5'd13: return IW'(8);
            5'd14: return IW'(4);
            5'd15: return IW'(2);
            5'd16: return IW'(1);
            5'd17: return IW'(1);
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [W2-1:0] v);
        if (v > MAXV)      return {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < MINV) return {1'b1, {(WIDTH-1){1'b0}}};
        else               return v[WIDTH-1:0];
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (enable) next_state = (operation <= OP_DIV) ? PREP : FIN;
            PREP: next_state = ITER;
            ITER: if (iter == CW'(ITERATIONS - 1)) next_state = FIN;
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy      = (state == PREP) || (state == ITER);
    assign dbg_state = state;

    // Initial vector, with the quadrant fold for rotation and the
    // left-half-plane mirror for vectoring.
    always_comb begin
        px    = sext(xq);
        py    = sext(yq);
        pz    = '0;
        pflip = 1'b0;
        poff  = '0;
        case (op_q)
            OP_SIN, OP_COS: begin
                px = K_C;
                py = '0;
                pz = sext(zq);
                if (pz > HALF_PI) begin
                    pz    = pz - PI_C;
                    pflip = 1'b1;
                end else if (pz < -HALF_PI) begin
                    pz    = pz + PI_C;
                    pflip = 1'b1;
                end
            end
            OP_ATAN, OP_MOD: begin
                if (xq[WIDTH-1]) begin
                    px = -sext(xq);
                    py = -sext(yq);
                    if (op_q == OP_ATAN) poff = yq[WIDTH-1] ? -PI_C : PI_C;
                end
            end
            OP_MULT: begin
                py = '0;
                pz = sext(zq);
            end
            default: ;
        endcase
    end

    // One micro-rotation. d_pos means d=+1.
    always_comb begin
        xs  = xr >>> iter;
        ys  = yr >>> iter;
        at  = atan_rom(iter);
        lin = ONE >>> iter;
        case (op_q)
            OP_SIN, OP_COS, OP_MULT: d_pos = ~zr[IW-1];
            OP_ATAN, OP_MOD:         d_pos = yr[IW-1];
            default:                 d_pos = yr[IW-1] ^ xr[IW-1];
        endcase
        y_n = d_pos ? (yr + xs) : (yr - xs);
        if (op_q == OP_MULT || op_q == OP_DIV) begin
            x_n = xr;
            z_n = d_pos ? (zr - lin) : (zr + lin);
        end else begin
            x_n = d_pos ? (xr - ys) : (xr + ys);
            z_n = d_pos ? (zr - at) : (zr + at);
        end
    end

    // Final result selection before saturation
    always_comb begin
        prod  = W2'(xr) * W2'(K_C);
        fin_w = '0;
        case (op_q)
            OP_SIN:  fin_w = W2'(flip_r ? -yr : yr);
            OP_COS:  fin_w = W2'(flip_r ? -xr : xr);
            OP_ATAN: fin_w = W2'(zr + off_r);
            OP_MOD:  fin_w = prod >>> FRAC;
            OP_MULT: fin_w = W2'(yr);
            OP_DIV:  fin_w = W2'(zr);
            default: fin_w = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            done     <= 1'b0;
            op_error <= 1'b0;
            iter     <= '0;
            op_q     <= '0;
            xq       <= '0;
            yq       <= '0;
            zq       <= '0;
            bad_q    <= 1'b0;
            xr       <= '0;
            yr       <= '0;
            zr       <= '0;
            off_r    <= '0;
            flip_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    op_q     <= operation;
                    xq       <= x_in;
                    yq       <= y_in;
                    zq       <= z_in;
                    bad_q    <= (operation > OP_DIV) ||
                                (operation == OP_DIV && x_in == '0);
                    done     <= 1'b0;
                    op_error <= 1'b0;
                end
                PREP: begin
                    xr     <= px;
                    yr     <= py;
                    zr     <= pz;
                    off_r  <= poff;
                    flip_r <= pflip;
                    iter   <= '0;
                end
                ITER: begin
                    xr   <= x_n;
                    yr   <= y_n;
                    zr   <= z_n;
                    iter <= iter + CW'(1);
                end
                FIN: begin
                    result   <= bad_q ? '0 : sat(fin_w);
                    op_error <= bad_q;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_seq_core.sv
// tb_cordic_seq_core: table-driven directed test of cordic_seq_core plus
// hand-written sequences for latency, hold, protocol abuse and mid-op reset.
module tb_cordic_seq_core;
    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [3:0]         operation;
    logic signed [31:0] x_in, y_in, z_in;
    logic signed [31:0] result;
    logic               done, busy, op_error;
    logic [1:0]         dbg_state;

    cordic_seq_core #(.WIDTH(32), .FRAC(16), .ITERATIONS(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .operation(operation),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .result(result),
        .done(done), .busy(busy), .op_error(op_error), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        int         x;
        int         y;
        int         z;
        int         exp;
        int         tol;
        bit         err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;
    localparam int TOL = 131;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    task automatic check_near(input string name, input longint act, input longint req, input int tol);
        check(name, (act - req <= tol) && (req - act <= tol), act, req);
    endtask

    // Issue one request, return edges from accept edge to done (sampled #1 after edges)
    task automatic run_op(input logic [3:0] op, input int x, input int y, input int z, output int lat);
        @(negedge clk);
        enable = 1'b1; operation = op; x_in = x; y_in = y; z_in = z;
        @(posedge clk); #1;
        enable = 1'b0;
        check("done_drop_on_accept", done == 1'b0, done, 0);
        lat = 0;
        while (!done && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_within_bound", done == 1'b1, lat, 18);
    endtask

    function automatic int q16(input real v);
        return $rtoi($floor(v * 65536.0 + 0.5));
    endfunction

    initial begin
        int  lat, deg, z;
        real rad;
        bit  ok;
        vec_t v;

        // SIN/COS sweep 0..360 in 15 degree steps, angle wrapped to [-180,180]
        for (int k = 0; k <= 24; k++) begin
            deg = k * 15;
            if (deg > 180) deg = deg - 360;
            rad = deg * 3.14159265358979 / 180.0;
            z   = q16(rad);
            vecs.push_back('{4'd0, 0, 0, z, q16($sin(z / 65536.0)), TOL, 1'b0});
            vecs.push_back('{4'd1, 0, 0, z, q16($cos(z / 65536.0)), TOL, 1'b0});
        end
        vecs.push_back('{4'd1, 0, 0, 171572, -56756, TOL, 1'b0});        // COS 150 deg
        vecs.push_back('{4'd4, 98304, 0, 81920, 122880, TOL, 1'b0});     // 1.5*1.25
        vecs.push_back('{4'd4, -131072, 0, 49152, -98304, TOL, 1'b0});   // -2*0.75
        vecs.push_back('{4'd5, 262144, 65536, 0, 16384, TOL, 1'b0});     // 1/4
        vecs.push_back('{4'd5, 0, 65536, 0, 0, 0, 1'b1});                // DIV by 0
        vecs.push_back('{4'd2, 65536, 65536, 0, 51472, TOL, 1'b0});      // atan 45 deg
        vecs.push_back('{4'd2, -65536, 65536, 0, 154416, TOL, 1'b0});    // 135 deg
        vecs.push_back('{4'd3, 196608, 262144, 0, 327680, TOL, 1'b0});   // |(3,4)|
        vecs.push_back('{4'd6, 65536, 65536, 65536, 0, 0, 1'b1});        // unsupported

        rst = 1'b1; enable = 1'b0; operation = '0; x_in = '0; y_in = '0; z_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result == 0, result, 0);
        check("reset_done", done == 1'b0, done, 0);
        check("reset_busy", busy == 1'b0, busy, 0);
        check("reset_op_error", op_error == 1'b0, op_error, 0);
        check("reset_state_idle", dbg_state == 2'd0, dbg_state, 0);
        @(negedge clk); rst = 1'b0;

        // Single-op latency and held result
        run_op(4'd0, 0, 0, 34315, lat);
        check("sin30_latency", lat == 18, lat, 18);
        check_near("sin30_result", result, 32768, TOL);
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!done || (result - 32768 > TOL) || (32768 - result > TOL)) ok = 1'b0;
        end
        check("sin30_hold_10_cycles", ok, result, 32768);

        // Table, back-to-back
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run_op(v.op, v.x, v.y, v.z, lat);
            check_near($sformatf("vec%0d_op%0d_result", i, v.op), result, v.exp, v.tol);
            check($sformatf("vec%0d_op%0d_op_error", i, v.op), op_error == v.err, op_error, v.err);
            if (v.op == 4'd6) check("unsupported_latency", lat == 1, lat, 1);
            else if (v.err) check("div0_latency", lat == 18, lat, 18);
        end

        // Enable pulsed during ITER is dropped
        @(negedge clk);
        enable = 1'b1; operation = 4'd0; x_in = 0; y_in = 0; z_in = 102944;
        @(posedge clk); #1;
        enable = 1'b0;
        lat = 0;
        repeat (7) begin @(posedge clk); lat++; end
        @(negedge clk);
        enable = 1'b1; operation = 4'd4; x_in = 65536; z_in = 65536;
        @(posedge clk); lat++;
        #1; enable = 1'b0;
        while (!done && lat < 64) begin @(posedge clk); #1; lat++; end
        check("abuse_latency", lat == 18, lat, 18);
        check_near("abuse_result_first_request", result, 65536, TOL);
        ok = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy || !done) ok = 1'b0;
        end
        check("abuse_no_second_done", ok, busy, 0);

        // Reset in the middle of iteration 7
        @(negedge clk);
        enable = 1'b1; operation = 4'd0; z_in = 34315;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_done", done == 1'b0, done, 0);
        check("midreset_busy", busy == 1'b0, busy, 0);
        check("midreset_result", result == 0, result, 0);
        @(negedge clk); rst = 1'b0;
        run_op(4'd0, 0, 0, 102944, lat);
        check("after_reset_latency", lat == 18, lat, 18);
        check_near("after_reset_sin90", result, 65536, TOL);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
